tune_arbiter: RTL and testbench
===============================

Name: tune_arbiter

Overview:
- Shares the single piezo tone path between three requesters: move-click, error beep and tour-complete fanfare.
- Latches request pulses, grants one tune at a time by fixed priority and sequences that tune's notes from an internal table.
- Generates the square-wave piezo/piezo_n drive directly.
- Sits between the tour control logic and the board piezo pins.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz; note periods = CLK_FREQ/f_note, integer-truncated.
- TICK_W, 20, one duration tick = 2^TICK_W clk cycles; benches use 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  request pulses; [2] fanfare (highest priority), [1] error, [0] click (lowest)
- abort  in  1  stop current tune and drop all pending requests
- piezo  out  1  tone drive
- piezo_n  out  1  complementary tone drive
- busy  out  1  high while in PLAY or GAP
- grant  out  3  one-hot: the tune currently in PLAY; 0 otherwise
- done  out  3  one-cycle pulse on the bit of a tune that completed normally
- note_per  out  15  current note period; 0 for a rest or when not playing

Behaviour:
- Reset: state IDLE; pending, grant, done, note_per, piezo and piezo_n all 0; all counters 0.
- Pending register, 3 bits:
  - Bit set on any clk edge where its req bit is 1.
  - Bit cleared when its tune is granted.
  - Set wins over a same-cycle clear, so a request arriving on the grant edge replays the tune.
- FSM states: IDLE, PLAY, GAP.
  - IDLE, any pending bit set: next edge -> PLAY. grant = highest-priority pending bit; that pending bit cleared; note index = 0; tick and duration counters = 0; tone counter = 0.
  - Latency: req high at edge k, then pending at k, then grant/busy at edge k+1.
  - PLAY: note index advances at the end of each note. At the end of the last note: done[granted] pulses for 1 cycle, grant -> 0, state -> GAP.
  - GAP: exactly 1 tick of silence, then IDLE. A waiting pending tune starts on the following edge.
  - Priority is non-preemptive: a higher request arriving mid-tune waits in pending.
- abort:
  - In PLAY or GAP: next edge -> IDLE, pending cleared, grant 0, no done pulse.
  - A req bit high in the same cycle as abort is dropped.
  - In IDLE: only clears pending.
- Duration timing:
  - tick_cnt is TICK_W bits, free-running within a note; a tick occurs when tick_cnt is all ones.
  - dur_cnt counts ticks. A note ends on the tick where dur_cnt == dur-1.
  - Each note therefore lasts exactly dur*2^TICK_W cycles.
  - Both counters clear at each note start.
- Tone generation:
  - f_cnt is 15 bits, cleared at note start and when f_cnt == note_per-1.
  - piezo = (f_cnt >= note_per>>1).
  - piezo_n = ~piezo during a non-rest note.
  - In a rest, IDLE or GAP: piezo = piezo_n = 0 and f_cnt is held at 0.
- Periods (default CLK_FREQ): D7 21285, E7 18960, F7 17895, A6 28409, REST 0.
- Tune table, note/ticks:
  - T0 click: D7/2. Total 2 ticks.
  - T1 error: A6/4, REST/2, A6/4. Total 10 ticks.
  - T2 fanfare: D7/8, E7/8, F7/8, E7/12, F7/4, D7/12, A6/4, D7/8. Total 64 ticks.
- note_per is combinational from the granted tune and note index. It changes on the same edge the note starts.

Test Plan (TICK_W=4, tick = 16 cycles):
- Reset then req=001 for 1 cycle at edge k -> grant=001 and busy from edge k+1; note_per=21285 for 32 cycles; done=001 for 1 cycle; busy low 16 cycles later; piezo toggles with half-period 10642/10643.
- req=011 in one cycle -> error tune plays first: grant=010, note_per 28409 (64 cycles), 0 (32 cycles, piezo=piezo_n=0), 28409 (64 cycles); then 16-cycle GAP; then click is granted.
- Fanfare run -> note_per sequence 21285, 18960, 17895, 18960, 17895, 21285, 28409, 21285 with durations 128/128/128/192/64/192/64/128 cycles; done=100 exactly 1024 cycles after grant.
- During fanfare, pulse req[0] and then abort at cycle 300 -> next edge busy=0, grant=0, no done pulse, click never plays.
- Pulse req[2] on the same edge the fanfare is granted -> fanfare replays after GAP (2 done pulses total).
- Assert rst_n low mid-tune -> all outputs 0 immediately (asynchronous); after release, stays IDLE with no pending.

Source files
------------

// File: rtl/tune_arbiter.sv
// Piezo tune arbiter: latches click/error/fanfare requests, plays one tune at a time
// by fixed priority from an internal note table, and drives the complementary piezo pins.
module tune_arbiter #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_W   = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic        abort,
   output logic        piezo,
   output logic        piezo_n,
   output logic        busy,
   output logic [2:0]  grant,
   output logic [2:0]  done,
   output logic [14:0] note_per
);

   localparam logic [14:0] PER_D7 = 15'(CLK_FREQ / 2349);
   localparam logic [14:0] PER_E7 = 15'(CLK_FREQ / 2637);
   localparam logic [14:0] PER_F7 = 15'(CLK_FREQ / 2794);
   localparam logic [14:0] PER_A6 = 15'(CLK_FREQ / 1760);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t            state_q;
   logic [2:0]        pend_q, pend_d;
   logic [2:0]        grant_q, done_q, idx_q;
   logic [TICK_W-1:0] tick_q;
   logic [3:0]        dur_q;
   logic [14:0]       f_q;

   logic [14:0] cur_per;
   logic [3:0]  cur_dur;
   logic        last_note;
   logic [2:0]  sel;
   logic        tick;

   // Note table lookup: period and length in ticks of the current note of the granted tune.
   always_comb begin
      cur_per   = '0;
      cur_dur   = 4'd1;
      last_note = 1'b1;
      case (grant_q)
         3'b001: begin
            cur_per = PER_D7;
            cur_dur = 4'd2;
         end
         3'b010: begin
            last_note = (idx_q == 3'd2);
            case (idx_q)
               3'd1:    begin cur_per = '0;     cur_dur = 4'd2; end
               default: begin cur_per = PER_A6; cur_dur = 4'd4; end
            endcase
         end
         3'b100: begin
            last_note = (idx_q == 3'd7);
            case (idx_q)
               3'd0:    begin cur_per = PER_D7; cur_dur = 4'd8;  end
               3'd1:    begin cur_per = PER_E7; cur_dur = 4'd8;  end
               3'd2:    begin cur_per = PER_F7; cur_dur = 4'd8;  end
               3'd3:    begin cur_per = PER_E7; cur_dur = 4'd12; end
               3'd4:    begin cur_per = PER_F7; cur_dur = 4'd4;  end
               3'd5:    begin cur_per = PER_D7; cur_dur = 4'd12; end
               3'd6:    begin cur_per = PER_A6; cur_dur = 4'd4;  end
               default: begin cur_per = PER_D7; cur_dur = 4'd8;  end
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      sel = 3'b000;
      if (pend_q[2])      sel = 3'b100;
      else if (pend_q[1]) sel = 3'b010;
      else if (pend_q[0]) sel = 3'b001;
   end

   // A new request wins over the clear of its own grant, so it replays.
   always_comb begin
      pend_d = pend_q | req;
      if (abort)                 pend_d = 3'b000;
      else if (state_q == S_IDLE) pend_d = (pend_q & ~sel) | req;
   end

   assign tick     = &tick_q;
   assign note_per = (state_q == S_PLAY) ? cur_per : '0;
   assign busy     = (state_q != S_IDLE);
   assign grant    = grant_q;
   assign done     = done_q;
   assign piezo    = (state_q == S_PLAY) && (note_per != '0) && (f_q >= (note_per >> 1));
   assign piezo_n  = (state_q == S_PLAY) && (note_per != '0) && !piezo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         grant_q <= '0;
         done_q  <= '0;
         idx_q   <= '0;
         tick_q  <= '0;
         dur_q   <= '0;
         f_q     <= '0;
      end else begin
         done_q <= '0;
         pend_q <= pend_d;
         if (abort) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            f_q     <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (|pend_q) begin
                     state_q <= S_PLAY;
                     grant_q <= sel;
                     idx_q   <= '0;
                     tick_q  <= '0;
                     dur_q   <= '0;
                     f_q     <= '0;
                  end
               end
               S_PLAY: begin
                  tick_q <= tick_q + 1'b1;
                  if (note_per == '0 || f_q == note_per - 15'd1) f_q <= '0;
                  else                                          f_q <= f_q + 15'd1;
                  if (tick) begin
                     if (dur_q == cur_dur - 4'd1) begin
                        dur_q <= '0;
                        f_q   <= '0;
                        if (last_note) begin
                           done_q  <= grant_q;
                           grant_q <= '0;
                           idx_q   <= '0;
                           state_q <= S_GAP;
                        end else begin
                           idx_q <= idx_q + 3'd1;
                        end
                     end else begin
                        dur_q <= dur_q + 4'd1;
                     end
                  end
               end
               S_GAP: begin
                  tick_q <= tick_q + 1'b1;
                  if (tick) state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tune_arbiter.sv
// Bench for tune_arbiter: a timeline model (elapsed cycles within a tune mapped onto the
// note table) checks two instances every cycle, one at 50 MHz and one at 50 kHz for audible toggling.
module tb_tune_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic        abort;
   logic        piezo_f, piezo_n_f, busy_f, piezo_s, piezo_n_s, busy_s;
   logic [2:0]  grant_f, done_f, grant_s, done_s;
   logic [14:0] note_per_f, note_per_s;

   int checks = 0;
   int failures = 0;
   int fan_done_cnt = 0;

   always #5 clk = ~clk;

   tune_arbiter #(.CLK_FREQ(50_000_000), .TICK_W(4)) dut_fast (
      .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
      .piezo(piezo_f), .piezo_n(piezo_n_f), .busy(busy_f),
      .grant(grant_f), .done(done_f), .note_per(note_per_f)
   );

   tune_arbiter #(.CLK_FREQ(50_000), .TICK_W(4)) dut_slow (
      .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
      .piezo(piezo_s), .piezo_n(piezo_n_s), .busy(busy_s),
      .grant(grant_s), .done(done_s), .note_per(note_per_s)
   );

   // Note codes: 0 rest, 1 D7, 2 E7, 3 F7, 4 A6.
   int tn_len   [3]    = '{1, 3, 8};
   int tn_total [3]    = '{2, 10, 64};
   int tn_note  [3][8] = '{'{1,0,0,0,0,0,0,0}, '{4,0,4,0,0,0,0,0}, '{1,2,3,2,3,1,4,1}};
   int tn_dur   [3][8] = '{'{2,0,0,0,0,0,0,0}, '{4,2,4,0,0,0,0,0}, '{8,8,8,12,4,12,4,8}};
   int per_fast [5]    = '{0, 21285, 18960, 17895, 28409};
   int note_hz  [5]    = '{0, 2349, 2637, 2794, 1760};

   int         m_tune;
   int         m_t;
   int         m_gap;
   logic [2:0] m_pend;
   logic [2:0] m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_tune = -1;
      m_t    = 0;
      m_gap  = 0;
      m_pend = 3'b000;
      m_done = 3'b000;
   endtask

   task automatic model_step(input logic [2:0] r, input logic a);
      m_done = 3'b000;
      if (a) begin
         m_tune = -1;
         m_gap  = 0;
         m_pend = 3'b000;
      end else begin
         if (m_tune >= 0) begin
            m_t++;
            if (m_t == 16 * tn_total[m_tune]) begin
               m_done = 3'(1 << m_tune);
               m_tune = -1;
               m_gap  = 16;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else if (m_pend != 3'b000) begin
            m_tune = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
            m_t    = 0;
            m_pend[m_tune] = 1'b0;
         end
         m_pend = m_pend | r;
      end
   endtask

   task automatic exp_note(input bit slow, output int per, output int off);
      int acc, d, n;
      per = 0;
      off = 0;
      acc = 0;
      if (m_tune >= 0) begin
         for (int i = 0; i < tn_len[m_tune]; i++) begin
            d = 16 * tn_dur[m_tune][i];
            n = tn_note[m_tune][i];
            if (m_t >= acc && m_t < acc + d) begin
               per = (n == 0) ? 0 : (slow ? 50_000 / note_hz[n] : per_fast[n]);
               off = m_t - acc;
            end
            acc += d;
         end
      end
   endtask

   task automatic check_all();
      int pf, of, ps, os;
      logic eb, epf, eps;
      logic [2:0] eg;
      exp_note(1'b0, pf, of);
      exp_note(1'b1, ps, os);
      eb  = (m_tune >= 0) || (m_gap > 0);
      eg  = (m_tune >= 0) ? 3'(1 << m_tune) : 3'b000;
      epf = (pf != 0) && ((of % pf) >= pf / 2);
      eps = (ps != 0) && ((os % ps) >= ps / 2);
      chk("busy_fast",     32'(busy_f),     32'(eb));
      chk("grant_fast",    32'(grant_f),    32'(eg));
      chk("done_fast",     32'(done_f),     32'(m_done));
      chk("note_per_fast", 32'(note_per_f), 32'(pf));
      chk("piezo_fast",    32'(piezo_f),    32'(epf));
      chk("piezo_n_fast",  32'(piezo_n_f),  32'((pf != 0) && !epf));
      chk("busy_slow",     32'(busy_s),     32'(eb));
      chk("grant_slow",    32'(grant_s),    32'(eg));
      chk("done_slow",     32'(done_s),     32'(m_done));
      chk("note_per_slow", 32'(note_per_s), 32'(ps));
      chk("piezo_slow",    32'(piezo_s),    32'(eps));
      chk("piezo_n_slow",  32'(piezo_n_s),  32'((ps != 0) && !eps));
      if (done_f[2] === 1'b1) fan_done_cnt++;
   endtask

   task automatic cyc(input logic [2:0] r, input logic a);
      req   = r;
      abort = a;
      @(posedge clk);
      model_step(r, a);
      #1;
      req   = 3'b000;
      abort = 1'b0;
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) cyc(3'b000, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b000;
      abort = 1'b0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      run(3);

      // Single click.
      cyc(3'b001, 1'b0);
      run(60);

      // Error and click together: error first, click after the gap.
      cyc(3'b011, 1'b0);
      run(260);

      // Fanfare; then a click arrives mid-tune and abort drops both.
      cyc(3'b100, 1'b0);
      run(1060);
      cyc(3'b100, 1'b0);
      cyc(3'b000, 1'b0);
      run(100);
      cyc(3'b001, 1'b0);
      run(198);
      cyc(3'b000, 1'b1);
      run(200);

      // Request landing on the grant edge replays the fanfare.
      fan_done_cnt = 0;
      cyc(3'b100, 1'b0);
      cyc(3'b100, 1'b0);
      run(2120);
      chk("fanfare_replay_done_count", 32'(fan_done_cnt), 32'd2);

      // Asynchronous reset in the middle of a tune with a request pending.
      cyc(3'b010, 1'b0);
      run(50);
      cyc(3'b001, 1'b0);
      run(10);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(40);

      // Random sparse requests with occasional abort.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) < 4) ? 3'($urandom_range(1, 7)) : 3'b000,
             ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0);
      end
      run(1200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
